fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC register and drives a single-outstanding instruction-memory request/response interface.
- Absorbs memory latency and pipeline stalls with a one-entry buffer.
- Presents a registered FetchInfo to decode. When no instruction is available, it presents a NOP bubble instead.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  out  PipeRequest  pipe requests; flush_req=4'b0000, stall_req=0 always (fetch never stalls or flushes others)
pipe  in  PipeControl  stall holds fetch_info; flush squashes fetch_info
branch_taken  in  1  redirect pulse from execute
branch_target  in  32  redirect PC
imem_req  out  1  request valid
imem_addr  out  32  request word address (PC)
imem_ready  in  1  request accepted when imem_req&&imem_ready
imem_rvalid  in  1  response valid; earliest one cycle after acceptance, in order
imem_rdata  in  32  instruction word
fetch_info  out  FetchInfo  registered {pc, inst} to decode
error  out  1  misaligned-redirect pulse

Behaviour:
- Reset values:
  - pc=RESET_PC; outstanding=0; drop=0; buf_valid=0.
  - fetch_info={pc:0, inst:NOP_INST}; error=0; imem_req=0 during rst.
- Internal state:
  - pc: next address to request.
  - outstanding: one request in flight.
  - drop: discard the next response.
  - buf_valid/buf_pc/buf_inst: one-entry skid buffer.
- Issue rule:
  - imem_req = !rst && !branch_taken && !buf_valid && (!outstanding || imem_rvalid) && !(imem_rvalid && pipe.stall).
  - imem_addr = pc.
  - On acceptance: pc <= pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0); outstanding <= 1.
  - A response and a new acceptance may occur in the same cycle, giving 1 instruction/cycle with single-cycle memory.
- Response handling: each response carries the pc of its request, held in a req_pc register.
  - drop set: discard the response, clear drop.
  - else if buf_valid: illegal (unreachable by the issue rule); the bench asserts on it.
  - else if !pipe.stall: fetch_info <= {req_pc, imem_rdata} at the next edge.
  - else: buffer into buf.
- fetch_info update priority per edge: rst > pipe.stall (hold) > pipe.flush (bubble) > buf_valid (drain buffer, clear buf_valid) > live response > bubble.
  - pipe.flush also clears buf_valid.
- Redirect (branch_taken=1), applied even while pipe.stall=1:
  - pc <= {branch_target[31:2], 2'b00}; buf_valid <= 0.
  - Any response arriving this cycle is discarded.
  - If outstanding and no response this cycle, drop <= 1.
  - No request is issued this cycle; the target is requested from the following cycle.
  - fetch_info is not cleared by redirect; squashing decode is pipe.flush's job.
- error: registered pulse, 1 for exactly one cycle after a redirect with branch_target[1:0]!=0.
- rst mid-transaction: all state cleared. A response arriving after reset with outstanding=0 is ignored.

Test Plan:
- Reset then zero-wait memory (ready=1, rvalid the cycle after acceptance) -> imem_addr 0,4,8,...; fetch_info.pc 0,4,8 on consecutive cycles from cycle 3; no bubbles.
- Memory latency 3 cycles -> imem_addr advances once per 3 cycles; fetch_info shows NOP_INST bubbles between instructions; req stays all-zero.
- pipe.stall high for 4 cycles while a response arrives -> fetch_info held; buf captures the instruction; no imem_req during the stall; after release, buffered pc=0x8 appears, then 0xC.
- branch_taken target 0x100 while the request for 0x10 is outstanding (rvalid 2 cycles later) -> 0x10 response discarded; next imem_addr=0x100; fetch_info never shows pc 0x10.
- branch_taken target 0x102 -> error=1 for exactly one cycle; next imem_addr=0x100.
- pipe.stall and pipe.flush together, then flush alone -> hold, then fetch_info={0, NOP_INST} and buf cleared; fetch resumes at the current pc.

Source files
------------

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem port and
// feeds decode a registered {pc, inst}, with a one-entry skid buffer for stalls.
package fetch_pkg;

   typedef struct packed {
      logic [3:0] flush_req;
      logic       stall_req;
   } PipeRequest;

   typedef struct packed {
      logic stall;
      logic flush;
   } PipeControl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } FetchInfo;

endpackage

module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output PipeRequest  req,
   input  PipeControl  pipe,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output FetchInfo    fetch_info,
   output logic        error
);

   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic        r_outstanding;
   logic        r_drop;
   logic        r_buf_valid;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_inst;
   FetchInfo    r_fetch_info;
   logic        r_error;

   logic        w_issue;
   logic        w_accept;
   logic        w_resp;
   logic        w_live;
   FetchInfo    w_bubble;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_req_pc_nxt;
   logic        w_outstanding_nxt;
   logic        w_drop_nxt;
   logic        w_buf_valid_nxt;
   logic [31:0] w_buf_pc_nxt;
   logic [31:0] w_buf_inst_nxt;
   FetchInfo    w_fetch_info_nxt;
   logic        w_error_nxt;

   // Fetch never asks the rest of the pipe to stall or flush.
   assign req        = '{flush_req: 4'b0000, stall_req: 1'b0};
   assign imem_req   = w_issue;
   assign imem_addr  = r_pc;
   assign fetch_info = r_fetch_info;
   assign error      = r_error;

   // Issue/response qualification and next-state for all fetch state.
   always_comb begin
      w_bubble          = '{pc: 32'h0000_0000, inst: NOP_INST};
      w_issue           = !rst && !branch_taken && !r_buf_valid
                          && (!r_outstanding || imem_rvalid)
                          && !(imem_rvalid && pipe.stall);
      w_accept          = w_issue && imem_ready;
      // A response with nothing outstanding is stale (e.g. from before reset).
      w_resp            = imem_rvalid && r_outstanding;
      w_live            = w_resp && !r_drop && !branch_taken;

      w_pc_nxt          = r_pc;
      w_req_pc_nxt      = r_req_pc;
      w_outstanding_nxt = r_outstanding;
      w_drop_nxt        = r_drop;
      w_buf_valid_nxt   = r_buf_valid;
      w_buf_pc_nxt      = r_buf_pc;
      w_buf_inst_nxt    = r_buf_inst;
      w_fetch_info_nxt  = r_fetch_info;
      w_error_nxt       = branch_taken && (branch_target[1:0] != 2'b00);

      if (branch_taken) begin
         w_pc_nxt = {branch_target[31:2], 2'b00};
      end else if (w_accept) begin
         w_pc_nxt     = r_pc + 32'd4;
         w_req_pc_nxt = r_pc;
      end else begin
         w_pc_nxt = r_pc;
      end

      if (w_accept) begin
         w_outstanding_nxt = 1'b1;
      end else if (w_resp) begin
         w_outstanding_nxt = 1'b0;
      end else begin
         w_outstanding_nxt = r_outstanding;
      end

      // A redirect with the old request still in flight must discard its reply.
      if (branch_taken) begin
         w_drop_nxt = r_outstanding && !imem_rvalid;
      end else if (w_resp) begin
         w_drop_nxt = 1'b0;
      end else begin
         w_drop_nxt = r_drop;
      end

      if (branch_taken || pipe.flush) begin
         w_buf_valid_nxt = 1'b0;
      end else if (pipe.stall) begin
         if (w_live) begin
            w_buf_valid_nxt = 1'b1;
            w_buf_pc_nxt    = r_req_pc;
            w_buf_inst_nxt  = imem_rdata;
         end else begin
            w_buf_valid_nxt = r_buf_valid;
         end
      end else begin
         w_buf_valid_nxt = 1'b0;
      end

      if (pipe.stall) begin
         w_fetch_info_nxt = r_fetch_info;
      end else if (pipe.flush) begin
         w_fetch_info_nxt = w_bubble;
      end else if (r_buf_valid) begin
         w_fetch_info_nxt = '{pc: r_buf_pc, inst: r_buf_inst};
      end else if (w_live) begin
         w_fetch_info_nxt = '{pc: r_req_pc, inst: imem_rdata};
      end else begin
         w_fetch_info_nxt = w_bubble;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= 32'h0000_0000;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
         r_buf_valid   <= 1'b0;
         r_buf_pc      <= 32'h0000_0000;
         r_buf_inst    <= 32'h0000_0000;
         r_fetch_info  <= '{pc: 32'h0000_0000, inst: NOP_INST};
         r_error       <= 1'b0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_req_pc      <= w_req_pc_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_drop        <= w_drop_nxt;
         r_buf_valid   <= w_buf_valid_nxt;
         r_buf_pc      <= w_buf_pc_nxt;
         r_buf_inst    <= w_buf_inst_nxt;
         r_fetch_info  <= w_fetch_info_nxt;
         r_error       <= w_error_nxt;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: a bench-side memory answers requests, and a
// monitor checks decode-side delivery against the expected program-order stream.
module tb_fetch;
   import fetch_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   PipeRequest  req;
   PipeControl  pipe;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   FetchInfo    fetch_info;
   logic        error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .req(req), .pipe(pipe),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .fetch_info(fetch_info), .error(error)
   );

   // Memory contents: low two bits are 00, so a word never equals the NOP encoding.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus knobs and bench memory state
   int          lat_min = 1, lat_max = 1, rdy_pct = 100, stall_pct = 0, br_pct = 0;
   int          cyc = 0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr;
   int          pend_cyc;

   // Scoreboard state
   logic [31:0] tgt_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_fetch = 32'h0;
   logic [31:0] fetch_start = 32'h0;
   FetchInfo    last_fi;
   int          n_deliv = 0;

   task automatic restart(input logic [31:0] a);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(a + 32'(4 * i));
   endtask

   task automatic step(input bit do_rst, input bit do_stall, input bit do_flush,
                       input bit do_br, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      cyc++;
      rst           = do_rst;
      pipe.stall    = do_stall;
      pipe.flush    = do_flush;
      branch_taken  = do_br;
      branch_target = tgt;
      if (do_br) tgt_q.push_back(tgt);
      imem_ready  = ($urandom_range(99) < rdy_pct);
      imem_rvalid = pend && (cyc >= pend_cyc);
      imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      @(negedge clk);
      if (imem_rvalid) pend = 1'b0;
      if (imem_req && imem_ready) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cyc  = cyc + int'($urandom_range(lat_max, lat_min));
      end
   endtask

   task automatic step_rand(input int n);
      bit          s, b;
      logic [31:0] t;
      for (int i = 0; i < n; i++) begin
         s = ($urandom_range(99) < stall_pct);
         b = ($urandom_range(99) < br_pct);
         t = $urandom_range(32'h0000_FFFF, 32'h0);
         step(1'b0, s, b, b, t);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Monitor: tracks expected stream across edges and checks outputs mid-cycle.
   initial begin
      bit          e_rst, e_stall, e_flush, e_br;
      logic [31:0] e_tgt, t;
      FetchInfo    bub;
      bub = '{pc: 32'h0, inst: NOP};
      forever begin
         @(posedge clk);
         e_rst = rst; e_stall = pipe.stall; e_flush = pipe.flush;
         e_br = branch_taken; e_tgt = branch_target;
         if (e_rst) begin
            exp_fetch = 32'h0;
            restart(32'h0);
         end else if (e_br) begin
            t = (tgt_q.size() > 0) ? tgt_q.pop_front() : 32'hFFFF_FFFF;
            exp_fetch = {t[31:2], 2'b00};
            restart({t[31:2], 2'b00});
         end else if (e_flush) begin
            restart(fetch_start);
         end
         @(negedge clk);
         check("req_zero", {59'b0, req}, 64'h0);
         if (e_rst) begin
            check("reset_info", fetch_info, bub);
            check("reset_error", {63'b0, error}, 64'h0);
         end else begin
            check("error_pulse", {63'b0, error}, {63'b0, e_br && (e_tgt[1:0] != 2'b00)});
            if (e_stall) begin
               check("stall_hold", fetch_info, last_fi);
            end else if (e_flush) begin
               check("flush_bubble", fetch_info, bub);
            end else if (fetch_info.inst != NOP) begin
               t = exp_q.pop_front();
               check("deliver_pc", {32'h0, fetch_info.pc}, {32'h0, t});
               check("deliver_inst", {32'h0, fetch_info.inst}, {32'h0, mem_word(t)});
               n_deliv++;
               if (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
            end
         end
         last_fi = fetch_info;
         if (rst || branch_taken || (imem_rvalid && pipe.stall)) check("req_blocked", {63'b0, imem_req}, 64'h0);
         if (imem_rvalid && dut.r_outstanding && !dut.r_drop && dut.r_buf_valid && !branch_taken)
            check("buf_overwrite", 64'h1, 64'h0);
         fetch_start = exp_fetch;
         if (imem_req && imem_ready) begin
            check("imem_addr", {32'h0, imem_addr}, {32'h0, exp_fetch});
            exp_fetch = exp_fetch + 32'd4;
         end
      end
   end

   initial begin
      int n0;
      rst = 1'b1; pipe = '0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Zero-wait memory: one instruction per cycle once streaming.
      idle(5);
      #1 n0 = n_deliv;
      idle(20);
      #1 check("throughput_1", n_deliv - n0, 20);

      // Three-cycle latency: one instruction every three cycles.
      lat_min = 3; lat_max = 3;
      idle(8);
      #1 n0 = n_deliv;
      idle(30);
      #1 check("throughput_3", n_deliv - n0, 10);

      // Stall while a response lands, then release; stall+flush, then flush alone.
      lat_min = 1; lat_max = 1;
      idle(4);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      idle(4);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      idle(6);

      // Misaligned redirect, then redirect near the top of the address space.
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
      idle(6);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF4);
      idle(8);

      // Randomized traffic with a reset in the middle.
      lat_min = 1; lat_max = 4; rdy_pct = 70; stall_pct = 25; br_pct = 4;
      step_rand(1500);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step_rand(1500);
      stall_pct = 0; br_pct = 0;
      idle(20);
      #1 check("delivered_min", {63'b0, n_deliv > 500}, 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
